// File: rtl/param_buffer.sv
// param_buffer: first-word-fall-through synchronous FIFO with a word count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Handshake: a write happens on a rising edge where data_in_valid=1 and
// data_in_ack=1 (ack = not full). A read happens on a rising edge where
// data_out_read=1 and data_out_valid=1 (valid = not empty). A write offered
// while full is dropped and sets overflow. A read issued while empty is
// ignored and sets underflow. Neither side may assume the other waits.
module param_buffer #(
  parameter int DATA_WIDTH   = 9,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_read,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = CW'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = CW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  do_write;
  logic                  do_read;

  // Full/empty come from the count, so equal pointers are never ambiguous.
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    do_write = data_in_valid & ~full & ~clear;
    do_read  = data_out_read & ~empty & ~clear;
  end

  // Status outputs are pure functions of the stored state.
  always_comb begin
    data_in_ack    = ~full;
    data_out_valid = ~empty;
    almost_full    = (count >= AFULL_CNT);
    almost_empty   = (count <= AEMPTY_CNT);
    data_out       = mem[rd_ptr];
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_in;
  end

  // Pointers and count; clear flushes ahead of any same-cycle transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_read)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (do_write && !do_read)      count <= count + CW'(1);
      else if (do_read && !do_write) count <= count - CW'(1);
    end
  end

  // Sticky error flags, cleared only by clear or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (data_in_valid && full)  overflow  <= 1'b1;
      if (data_out_read && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_buffer.sv
// Testbench for param_buffer: directed scenarios plus random traffic, all
// checked against a queue-based reference of the FIFO's behaviour.
module tb_param_buffer;

  localparam int DW    = 9;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ack;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_read;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  param_buffer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFL),
    .AEMPTY_LEVEL(AEL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ack   (data_in_ack),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_read (data_out_read),
    .count         (count),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  logic          exp_unf;
  int            n_cmp;
  int            n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  // Compare every visible output with what the queue model says.
  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".ack"},    32'(data_in_ack),    32'(n != DEPTH));
    check({tag, ".dvalid"}, 32'(data_out_valid), 32'(n != 0));
    if (n != 0) check({tag, ".dout"}, 32'(data_out), 32'(exp_q[0]));
    check({tag, ".count"},  32'(count),          32'(n));
    check({tag, ".afull"},  32'(almost_full),    32'(n >= AFL));
    check({tag, ".aempty"}, 32'(almost_empty),   32'(n <= AEL));
    check({tag, ".ovf"},    32'(overflow),       32'(exp_ovf));
    check({tag, ".unf"},    32'(underflow),      32'(exp_unf));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; drives, checks, advances one cycle.
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic r, input logic c);
    int n;
    data_in_valid = v;
    data_in       = d;
    data_out_read = r;
    clear         = c;
    #1;
    check_outputs(tag);
    n = exp_q.size();
    if (c) begin
      model_reset();
    end else begin
      if (v && n == DEPTH) exp_ovf = 1'b1;
      if (r && n == 0)     exp_unf = 1'b1;
      if (r && n != 0)     void'(exp_q.pop_front());
      if (v && n != DEPTH) exp_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    data_in_valid = 1'b0;
    data_out_read = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step("clr", 1'b0, '0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst           = 1'b0;
    clear         = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    data_out_read = 1'b0;

    // Reset state
    #1;
    check("rst.ack",    32'(data_in_ack),    32'd1);
    check("rst.dvalid", 32'(data_out_valid), 32'd0);
    check("rst.afull",  32'(almost_full),    32'd0);
    check("rst.aempty", 32'(almost_empty),   32'd1);
    check("rst.count",  32'(count),          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Three writes then three reads, in order
    step("s1w", 1'b1, 9'h1FF, 1'b0, 1'b0);
    step("s1w", 1'b1, 9'h00F, 1'b0, 1'b0);
    step("s1w", 1'b1, 9'h003, 1'b0, 1'b0);
    #1;
    check("s1.count3", 32'(count),    32'd3);
    check("s1.head",   32'(data_out), 32'h1FF);
    for (int i = 0; i < 3; i++) step("s1r", 1'b0, '0, 1'b1, 1'b0);
    #1;
    check("s1.empty", 32'(data_out_valid), 32'd0);

    // Overfill: nine writes, ninth dropped
    for (int i = 1; i <= 9; i++) begin
      step("s2w", 1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 8) begin
        #1;
        check("s2.ack_full", 32'(data_in_ack), 32'd0);
      end
    end
    #1;
    check("s2.ovf",   32'(overflow),    32'd1);
    check("s2.count", 32'(count),       32'd8);
    check("s2.afull", 32'(almost_full), 32'd1);
    for (int i = 0; i < 8; i++) step("s2r", 1'b0, '0, 1'b1, 1'b0);
    do_clear();

    // Steady streaming at six words, pointers wrap several times
    for (int i = 0; i < 6; i++) step("s3f", 1'b1, DW'(16 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("s3s", 1'b1, DW'(22 + i), 1'b1, 1'b0);
    #1;
    check("s3.count6", 32'(count),    32'd6);
    check("s3.head",   32'(data_out), 32'd36);
    do_clear();

    // Read on empty with simultaneous write
    step("s4", 1'b1, 9'h0AA, 1'b1, 1'b0);
    #1;
    check("s4.unf",   32'(underflow), 32'd1);
    check("s4.count", 32'(count),     32'd1);
    check("s4.dout",  32'(data_out),  32'h0AA);
    do_clear();

    // Full with simultaneous write and read
    for (int i = 0; i < 8; i++) step("s5f", 1'b1, DW'(100 + i), 1'b0, 1'b0);
    step("s5", 1'b1, 9'h1EE, 1'b1, 1'b0);
    #1;
    check("s5.count7", 32'(count),    32'd7);
    check("s5.ovf",    32'(overflow), 32'd1);
    check("s5.head",   32'(data_out), 32'd101);
    do_clear();

    // Clear beats a same-cycle write
    for (int i = 0; i < 5; i++) step("s6f", 1'b1, DW'(200 + i), 1'b0, 1'b0);
    step("s6c", 1'b1, 9'h055, 1'b0, 1'b1);
    #1;
    check("s6.count0", 32'(count),    32'd0);
    check("s6.ovf",    32'(overflow), 32'd0);
    check("s6.unf",    32'(underflow),32'd0);

    // Asynchronous reset between edges with three words stored
    for (int i = 0; i < 3; i++) step("s7f", 1'b1, DW'(300 + i), 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("s7.dvalid", 32'(data_out_valid), 32'd0);
    check("s7.count",  32'(count),          32'd0);
    check("s7.ack",    32'(data_in_ack),    32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step("s7w", 1'b1, 9'h13C, 1'b0, 1'b0);
    #1;
    check("s7.count1", 32'(count),    32'd1);
    check("s7.dout",   32'(data_out), 32'h13C);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic v, r, c;
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 2) == 0);
      c = 1'($urandom_range(0, 63) == 0);
      step("rnd", v, DW'($urandom), r, c);
    end
    idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_buffer.md
PARAM_BUFFER -- requirements
Module: param_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 9: data word width in bits, allowed range 1..32.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3: storage depth DEPTH = 2^ADDR_WIDTH words, allowed range 1..8.
REQ-003 The block SHALL have parameter AFULL_LEVEL, default 6: almost_full threshold in words, allowed range 1..DEPTH.
REQ-004 The block SHALL have parameter AEMPTY_LEVEL, default 1: almost_empty threshold in words, allowed range 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous flush, active-high.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 data_in_valid  input  1  source offers data_in this cycle.
REQ-010 data_in_ack  output  1  buffer can accept a word this cycle; combinational, equal to NOT full.
REQ-011 data_out  output  DATA_WIDTH  head-of-queue word (first-word-fall-through).
REQ-012 data_out_valid  output  1  data_out holds a valid word; equal to NOT empty.
REQ-013 data_out_read  input  1  sink consumes the head word this cycle.
REQ-014 count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
REQ-015 almost_full  output  1  count >= AFULL_LEVEL.
REQ-016 almost_empty  output  1  count <= AEMPTY_LEVEL.
REQ-017 overflow  output  1  sticky flag: a write was offered while the buffer was full.
REQ-018 underflow  output  1  sticky flag: a read was issued while the buffer was empty.

Function
REQ-019 A write SHALL occur on a rising edge where data_in_valid=1 and data_in_ack=1; the word is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-020 A read SHALL occur on a rising edge where data_out_read=1 and data_out_valid=1; the read pointer increments modulo DEPTH.
REQ-021 Write-to-output latency SHALL be one cycle: a word written into an empty buffer at edge N appears on data_out, with data_out_valid=1, immediately after edge N.
REQ-022 data_out SHALL always present the word at the read pointer and SHALL be stable while data_out_valid=1 and no read occurs.
REQ-023 count SHALL change by +1 on a write only, by -1 on a read only, and SHALL be unchanged on a simultaneous write and read.
REQ-024 Full (count=DEPTH) SHALL force data_in_ack=0; an offered word SHALL be dropped and overflow set to 1, while a read in the same cycle proceeds normally.
REQ-025 Empty (count=0) SHALL force data_out_valid=0; data_out_read SHALL be ignored and underflow set to 1, while a write in the same cycle proceeds normally.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 with no gap and no data loss; full and empty SHALL be distinguished by count, not by pointer equality.
REQ-027 overflow and underflow SHALL remain 1 until clear or reset.
REQ-028 clear=1 SHALL, on the next edge, zero both pointers, count, overflow and underflow; clear SHALL take priority over any write or read in the same cycle.
REQ-029 Storage contents SHALL NOT need to be reset; data_out is don't-care while data_out_valid=0.
REQ-030 almost_full and almost_empty SHALL be combinational functions of count only.

Reset
REQ-031 rst=0 SHALL, asynchronously and without waiting for a clock edge, set pointers=0, count=0, overflow=0 and underflow=0; the resulting outputs SHALL be data_in_ack=1, data_out_valid=0, almost_full=0 and almost_empty=1.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; the first write after rst returns to 1 SHALL be accepted on the first rising edge at which rst=1.

Verification (defaults DATA_WIDTH=9, depth 8)
REQ-033 Write 0x1FF, 0x00F, 0x003 on consecutive cycles with no reads -> count=3, data_out=0x1FF; three reads then return 0x1FF, 0x00F, 0x003 in order, ending with count=0 and data_out_valid=0.
REQ-034 Write 9 words 1..9 with no reads -> data_in_ack=0 after the 8th write, word 9 dropped, overflow=1, count=8, almost_full=1; 8 reads return 1..8.
REQ-035 Fill 6 words, then hold valid and read high for 20 cycles -> count stays at 6, the output sequence is strictly in order, and the pointers wrap at least twice.
REQ-036 Empty buffer, read pulsed with a simultaneous write of 0x0AA -> underflow=1, count=1, data_out=0x0AA after the edge.
REQ-037 Full buffer with simultaneous write and read -> the read proceeds, the write is dropped, count=7, overflow=1.
REQ-038 With 5 words stored, pulse clear together with a write -> count=0 and flags=0 after the edge; then assert rst=0 between clock edges with 3 words stored -> data_out_valid drops immediately and count=0.
